io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 8: UART TX FIFO entries (power of two, >=4).
REQ-002 Parameter FULL_MARGIN, default 2: free-entry margin below which io_buffer_full asserts.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 rdy_in  input  1  when low, freeze all state except the cycle counter.
REQ-006 cpu_a  input  32  CPU byte address; I/O space when cpu_a[17:16]==2'b11.
REQ-007 cpu_dout  input  8  CPU write data.
REQ-008 cpu_wr  input  1  1=write, 0=read.
REQ-009 cpu_din  output  8  read data to CPU, valid the cycle after the address.
REQ-010 io_buffer_full  output  1  back-pressure to CPU for I/O writes.
REQ-011 ram_a  output  17  RAM address (cpu_a[16:0]).
REQ-012 ram_dout / ram_we / ram_din  output 8 / output 1 / input 8  synchronous RAM port; ram_din valid one cycle after ram_a.
REQ-013 uart_tx_data / uart_tx_valid / uart_tx_ready  output 8 / output 1 / input 1  valid-ready byte sink.
REQ-014 uart_rx_data / uart_rx_valid / uart_rx_pop  input 8 / input 1 / output 1  RX byte source; pop consumes one byte.
REQ-015 program_finish  output  1  sticky end-of-program flag.
REQ-016 tx_overflow  output  1  sticky flag: I/O write dropped because FIFO full.

Function
REQ-017 Decode: RAM when cpu_a[17:16]!=2'b11 and cpu_a<0x20000; I/O when [17:16]==2'b11; otherwise unmapped.
REQ-018 ram_we = cpu_wr & RAM-decode & rdy_in, combinational; ram_a/ram_dout pass through.
REQ-019 Unmapped write: no effect; unmapped read: cpu_din=0x00.
REQ-020 Source select registered each ready cycle (RAM/IO/zero); cpu_din = RAM ? ram_din : io_rdata_q; latency exactly 1 cycle for all spaces.
REQ-021 Write 0x30000, data!=0x00: push byte to TX FIFO; data==0x00: ignored.
REQ-022 Write 0x30004: push 0x00 to TX FIFO and set program_finish (sticky until reset).
REQ-023 Push while FIFO full: byte dropped, tx_overflow set (sticky), count unchanged.
REQ-024 FIFO head drives uart_tx_data; uart_tx_valid = count!=0; pop on valid&ready.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance; push on full with same-cycle pop succeeds.
REQ-026 Pointers wrap modulo TX_DEPTH; count width log2(TX_DEPTH)+1.
REQ-027 io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN, combinational from registered count.
REQ-028 Read 0x30000: io_rdata_q = uart_rx_valid ? uart_rx_data : 0x00; uart_rx_pop pulses 1 cycle only when uart_rx_valid.
REQ-029 32-bit free-running cycle counter, +1 every clock after reset regardless of rdy_in, wraps 0xFFFFFFFF->0.
REQ-030 Read 0x30004: snapshot counter, return byte 0; reads 0x30005-0x30007 return bytes 1-3 of snapshot (little-endian).
REQ-031 Other I/O addresses: reads return 0x00, writes ignored.
REQ-032 rdy_in low: no push/pop, no rx_pop, select/io_rdata_q hold; uart_tx_valid still reflects count.

Reset
REQ-033 On rst_in: FIFO pointers/count=0, counter=0, snapshot=0, io_rdata_q=0, select=zero, program_finish=0, tx_overflow=0, uart_rx_pop=0.
REQ-034 Reset mid-transfer discards FIFO contents; uart_tx_valid deasserts asynchronously.

Structure
REQ-035 Address constants (IO_BASE 0x30000, IO_CLK 0x30004, RAM_LIMIT 0x20000) and select encoding live in the shared config header.
REQ-036 TX FIFO is one sub-module, io_tx_fifo (param depth; push/pop/full/empty/count).

Verification
REQ-037 Write 0x41 to 0x30000, uart_tx_ready=1 -> uart_tx_data=0x41, valid next cycle, FIFO empty one cycle later.
REQ-038 uart_tx_ready=0, 6 writes -> io_buffer_full=1 after 6th; 9 writes -> tx_overflow=1, count=8.
REQ-039 Counter=0x12345678 at read of 0x30004..0x30007 -> cpu_din 0x78,0x56,0x34,0x12 on successive cycles.
REQ-040 Write 0x00 to 0x30000 -> no push; write to 0x30004 -> program_finish=1, 0x00 emitted on TX.
REQ-041 Read 0x00100 with ram_din=0xAB -> cpu_din=0xAB next cycle; write 0x25000 -> ram_we=0.
REQ-042 Assert rst_in with 3 queued bytes -> uart_tx_valid=0 immediately, all flags 0.

Source files
------------

// File: rtl/io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : io_bridge_pkg
//  Purpose : Shared address map, source-select encoding and decode helper
//            for the CPU I/O bridge.
//  Rev     : 1.0  initial release
// ============================================================================
package io_bridge_pkg;

    // I/O register offsets, compared against cpu_a[17:0]
    localparam logic [17:0] IO_BASE   = 18'h3_0000;
    localparam logic [17:0] IO_CLK    = 18'h3_0004;
    // First byte address above the RAM window
    localparam logic [31:0] RAM_LIMIT = 32'h0002_0000;
    // Value of cpu_a[17:16] selecting the I/O window
    localparam logic [1:0]  IO_SPACE  = 2'b11;

    // Source of the registered read data returned on cpu_din
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } src_sel_e;

    typedef struct packed {
        logic is_ram;
        logic is_io;
    } decode_t;

    // I/O wins on [17:16]==11 regardless of upper bits; RAM needs a full
    // 32-bit compare so aliases above 128 KiB fall into the unmapped hole.
    function automatic decode_t decode_addr(input logic [31:0] a);
        decode_t d;
        d.is_io  = (a[17:16] == IO_SPACE);
        d.is_ram = !d.is_io && (a < RAM_LIMIT);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : io_tx_fifo
//  Purpose : Power-of-two byte FIFO feeding the UART transmitter. A push
//            while full is ignored unless a pop happens in the same cycle.
//  Rev     : 1.0  initial release
// ============================================================================
module io_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];

    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents are meaningless while empty so no reset
    always_ff @(posedge clk_in) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : io_bridge
//  Purpose : CPU bus bridge splitting accesses between synchronous RAM, a
//            small I/O register window (UART TX/RX, cycle counter, finish
//            flag) and an unmapped hole that reads as zero.
//  Rev     : 1.0  initial release
// ============================================================================
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_pop,
    output logic        program_finish,
    output logic        tx_overflow
);

    localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    decode_t     w_dec;
    logic [17:0] w_off;
    logic        w_io_wr;
    logic        w_io_rd;

    assign w_dec   = decode_addr(cpu_a);
    assign w_off   = cpu_a[17:0];
    assign w_io_wr = rdy_in &  cpu_wr & w_dec.is_io;
    assign w_io_rd = rdy_in & ~cpu_wr & w_dec.is_io;

    // RAM port is a straight pass-through; only the strobe is qualified
    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr & w_dec.is_ram & rdy_in;

    // ------------------------------------------------------------------
    // UART TX path
    // ------------------------------------------------------------------
    logic             w_wr_tx;
    logic             w_wr_clk;
    logic             w_push;
    logic [7:0]       w_push_data;
    logic             w_pop;
    logic             w_drop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_count;

    // A zero byte to the TX port is treated as "no data"; the finish port
    // always emits a single 0x00 as an end-of-stream marker.
    assign w_wr_tx     = w_io_wr & (w_off == IO_BASE) & (cpu_dout != 8'h00);
    assign w_wr_clk    = w_io_wr & (w_off == IO_CLK);
    assign w_push      = w_wr_tx | w_wr_clk;
    assign w_push_data = w_wr_clk ? 8'h00 : cpu_dout;
    assign w_pop       = rdy_in & uart_tx_valid & uart_tx_ready;
    assign w_drop      = w_push & w_fifo_full & ~w_pop;

    io_tx_fifo #(
        .DEPTH   (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (uart_tx_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_count)
    );

    assign uart_tx_valid  = ~w_fifo_empty;
    assign io_buffer_full = (TX_DEPTH - 32'(w_count)) <= FULL_MARGIN;

    // ------------------------------------------------------------------
    // Cycle counter and read path
    // ------------------------------------------------------------------
    logic [31:0] cycle_q;
    logic [31:0] snap_q,      snap_d;
    logic [7:0]  io_rdata_q,  io_rdata_d;
    src_sel_e    sel_q,       sel_d;
    logic        rx_pop_q,    rx_pop_d;

    // Free-running counter, deliberately not gated by rdy_in
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cycle_q <= '0;
        else        cycle_q <= cycle_q + 32'd1;
    end

    // Read-source select, I/O read data and side effects of I/O reads
    always_comb begin
        sel_d      = sel_q;
        io_rdata_d = io_rdata_q;
        snap_d     = snap_q;
        rx_pop_d   = 1'b0;
        if (rdy_in) begin
            io_rdata_d = 8'h00;
            if (w_dec.is_ram)      sel_d = SEL_RAM;
            else if (w_dec.is_io)  sel_d = SEL_IO;
            else                   sel_d = SEL_ZERO;
            if (w_io_rd) begin
                case (w_off)
                    IO_BASE: begin
                        io_rdata_d = uart_rx_valid ? uart_rx_data : 8'h00;
                        rx_pop_d   = uart_rx_valid;
                    end
                    // Byte 0 comes live from the counter so the snapshot
                    // and the returned byte describe the same cycle.
                    IO_CLK: begin
                        snap_d     = cycle_q;
                        io_rdata_d = cycle_q[7:0];
                    end
                    IO_CLK + 18'd1: io_rdata_d = snap_q[15:8];
                    IO_CLK + 18'd2: io_rdata_d = snap_q[23:16];
                    IO_CLK + 18'd3: io_rdata_d = snap_q[31:24];
                    default:        io_rdata_d = 8'h00;
                endcase
            end
        end
    end

    // Read-path registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sel_q      <= SEL_ZERO;
            io_rdata_q <= 8'h00;
            snap_q     <= '0;
            rx_pop_q   <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            io_rdata_q <= io_rdata_d;
            snap_q     <= snap_d;
            rx_pop_q   <= rx_pop_d;
        end
    end

    assign uart_rx_pop = rx_pop_q;

    // Return data mux: RAM data arrives from the RAM one cycle after the
    // address, matching the registered I/O data
    always_comb begin
        cpu_din = 8'h00;
        case (sel_q)
            SEL_RAM: cpu_din = ram_din;
            SEL_IO:  cpu_din = io_rdata_q;
            default: cpu_din = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------
    logic finish_q, finish_d;
    logic ovf_q,    ovf_d;

    // Flags only ever set; cleared by reset
    always_comb begin
        finish_d = finish_q | w_wr_clk;
        ovf_d    = ovf_q    | w_drop;
    end

    // Flag registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            finish_q <= finish_d;
            ovf_q    <= ovf_d;
        end
    end

    assign program_finish = finish_q;
    assign tx_overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : tb_io_bridge
//  Purpose : Self-checking bench for io_bridge: decode table, UART TX FIFO
//            scoreboard, RX pop, cycle-counter snapshot, rdy_in stall and
//            asynchronous reset.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_io_bridge;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_pop;
    logic        program_finish;
    logic        tx_overflow;

    io_bridge #(
        .TX_DEPTH       (DEPTH),
        .FULL_MARGIN    (MARGIN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_pop    (uart_rx_pop),
        .program_finish (program_finish),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  ram_data;
        logic [7:0]  exp_din;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic       chk;
        logic [7:0] val;
    } din_exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tx_q [$];
    din_exp_t    din_q [$];
    logic        m_ovf = 1'b0;
    logic        m_fin = 1'b0;
    logic        m_pop = 1'b0;
    logic [31:0] m_cyc;

    // Reference cycle count: what the DUT counter should hold right now
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) m_cyc <= 32'd0;
        else        m_cyc <= m_cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle, entered at posedge+1: drive, check outputs of the
    // previous edge, advance the reference model, then cross the next edge.
    task automatic cyc(input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic dchk, input logic [7:0] dexp,
                       input logic wechk, input logic weexp);
        din_exp_t   e;
        logic       pop, push, full_before;
        logic [7:0] pb;
        cpu_wr   = wr;
        cpu_a    = a;
        cpu_dout = d;
        #1;
        if (din_q.size() > 0) begin
            e = din_q.pop_front();
            if (e.chk) chk("cpu_din", {24'd0, cpu_din}, {24'd0, e.val});
        end
        if (wechk) chk("ram_we", {31'd0, ram_we}, {31'd0, weexp});
        chk("rx_pop",      {31'd0, uart_rx_pop},    {31'd0, m_pop});
        chk("tx_valid",    {31'd0, uart_tx_valid},  (tx_q.size() != 0) ? 32'd1 : 32'd0);
        if (tx_q.size() != 0) chk("tx_data", {24'd0, uart_tx_data}, {24'd0, tx_q[0]});
        chk("buf_full",    {31'd0, io_buffer_full}, ((DEPTH - tx_q.size()) <= MARGIN) ? 32'd1 : 32'd0);
        chk("tx_overflow", {31'd0, tx_overflow},    {31'd0, m_ovf});
        chk("finish",      {31'd0, program_finish}, {31'd0, m_fin});

        full_before = (tx_q.size() == DEPTH);
        pop  = rdy_in && uart_tx_ready && (tx_q.size() != 0);
        push = rdy_in && wr && ((a[17:0] == 18'h30000 && d != 8'h00) || a[17:0] == 18'h30004);
        pb   = (a[17:0] == 18'h30004) ? 8'h00 : d;
        if (push && full_before && !pop) m_ovf = 1'b1;
        if (pop) void'(tx_q.pop_front());
        if (push && (!full_before || pop)) tx_q.push_back(pb);
        if (rdy_in && wr && a[17:0] == 18'h30004) m_fin = 1'b1;
        m_pop = rdy_in && !wr && (a[17:0] == 18'h30000) && uart_rx_valid;
        e.chk = dchk;
        e.val = dexp;
        din_q.push_back(e);
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input logic [7:0] dexp_prev_unused);
        cyc(1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    // Hard stop if something stalls the bench
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [12];
        din_exp_t    e0;
        logic [31:0] snap;
        logic [31:0] snap2;

        vecs[0]  = '{32'h0000_0100, 1'b0, 8'h00, 8'hAB, 8'hAB, 1'b0};
        vecs[1]  = '{32'h0000_0200, 1'b1, 8'h55, 8'h11, 8'h11, 1'b1};
        vecs[2]  = '{32'h0002_5000, 1'b1, 8'h77, 8'h22, 8'h00, 1'b0};
        vecs[3]  = '{32'h0002_5000, 1'b0, 8'h00, 8'hCC, 8'h00, 1'b0};
        vecs[4]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0};
        vecs[5]  = '{32'h0001_FFFF, 1'b1, 8'h5A, 8'h44, 8'h44, 1'b1};
        vecs[6]  = '{32'h0002_0000, 1'b0, 8'h00, 8'h99, 8'h00, 1'b0};
        vecs[7]  = '{32'h0003_0010, 1'b0, 8'h00, 8'h66, 8'h00, 1'b0};
        vecs[8]  = '{32'h0004_0100, 1'b0, 8'h00, 8'h77, 8'h00, 1'b0};
        vecs[9]  = '{32'hFFF3_0008, 1'b1, 8'h33, 8'h88, 8'h00, 1'b0};
        vecs[10] = '{32'h0000_0000, 1'b0, 8'h00, 8'h5E, 8'h5E, 1'b0};
        vecs[11] = '{32'hFFF3_0010, 1'b0, 8'h00, 8'h12, 8'h00, 1'b0};

        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        cpu_a         = 32'h0003_0008;
        cpu_dout      = 8'h00;
        cpu_wr        = 1'b0;
        ram_din       = 8'h00;
        uart_tx_ready = 1'b1;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;

        // Reset state
        #1;
        chk("rst_tx_valid", {31'd0, uart_tx_valid},  32'd0);
        chk("rst_full",     {31'd0, io_buffer_full}, 32'd0);
        chk("rst_finish",   {31'd0, program_finish}, 32'd0);
        chk("rst_overflow", {31'd0, tx_overflow},    32'd0);
        chk("rst_rx_pop",   {31'd0, uart_rx_pop},    32'd0);
        chk("rst_cpu_din",  {24'd0, cpu_din},        32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        e0.chk = 1'b1;
        e0.val = 8'h00;
        din_q.push_back(e0);

        // Decode table
        for (int i = 0; i < 12; i++) begin
            ram_din = (i > 0) ? vecs[i-1].ram_data : 8'h00;
            cyc(vecs[i].wr, vecs[i].a, vecs[i].d, 1'b1, vecs[i].exp_din, 1'b1, vecs[i].exp_we);
        end
        ram_din = vecs[11].ram_data;
        idle(8'h00);
        ram_din = 8'h00;

        // Single TX byte drains one cycle after appearing
        uart_tx_ready = 1'b1;
        cyc(1'b1, 32'h0003_0000, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        idle(8'h00);

        // Zero byte ignored; finish port emits 0x00 and sets the flag
        cyc(1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        cyc(1'b1, 32'h0003_0004, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        idle(8'h00);

        // Fill with a stalled sink, push-on-full with pop, then overflow
        uart_tx_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 32'h0003_0000, 8'(8'h11 + k), 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        uart_tx_ready = 1'b1;
        cyc(1'b1, 32'h0003_0000, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
        uart_tx_ready = 1'b0;
        cyc(1'b1, 32'h0003_0000, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        // Stall: sink ready but bridge not ready, write ignored
        uart_tx_ready = 1'b1;
        rdy_in = 1'b0;
        cyc(1'b1, 32'h0003_0000, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'h5D, 1'b0, 8'h00, 1'b0, 1'b0);
        rdy_in = 1'b1;
        for (int k = 0; k < 12 && tx_q.size() != 0; k++) idle(8'h00);
        chk("drain_empty", {31'd0, uart_tx_valid}, 32'd0);

        // RX: read with data, stalled read, read with no data
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h5A;
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
        rdy_in = 1'b0;
        uart_rx_data = 8'h6B;
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
        rdy_in = 1'b1;
        uart_rx_valid = 1'b0;
        cyc(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(8'h00);

        // Cycle counter snapshot, with a stall between bytes
        for (int k = 0; k < 300; k++) idle(8'h00);
        snap = m_cyc;
        cyc(1'b0, 32'h0003_0004, 8'h00, 1'b1, snap[7:0], 1'b0, 1'b0);
        rdy_in = 1'b0;
        cyc(1'b0, 32'h0003_0005, 8'h00, 1'b1, snap[7:0], 1'b0, 1'b0);
        cyc(1'b0, 32'h0003_0006, 8'h00, 1'b1, snap[7:0], 1'b0, 1'b0);
        rdy_in = 1'b1;
        cyc(1'b0, 32'h0003_0005, 8'h00, 1'b1, snap[15:8],  1'b0, 1'b0);
        cyc(1'b0, 32'h0003_0006, 8'h00, 1'b1, snap[23:16], 1'b0, 1'b0);
        cyc(1'b0, 32'h0003_0007, 8'h00, 1'b1, snap[31:24], 1'b0, 1'b0);
        snap2 = m_cyc;
        cyc(1'b0, 32'h0003_0004, 8'h00, 1'b1, snap2[7:0],  1'b0, 1'b0);
        cyc(1'b0, 32'h0003_0005, 8'h00, 1'b1, snap2[15:8], 1'b0, 1'b0);
        idle(8'h00);

        // Reset with bytes queued: valid drops before any clock edge
        uart_tx_ready = 1'b0;
        cyc(1'b1, 32'h0003_0004, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'h21, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 32'h0003_0000, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_tx_valid", {31'd0, uart_tx_valid},  32'd0);
        chk("arst_full",     {31'd0, io_buffer_full}, 32'd0);
        chk("arst_finish",   {31'd0, program_finish}, 32'd0);
        chk("arst_overflow", {31'd0, tx_overflow},    32'd0);
        chk("arst_rx_pop",   {31'd0, uart_rx_pop},    32'd0);
        chk("arst_cpu_din",  {24'd0, cpu_din},        32'd0);
        tx_q.delete();
        din_q.delete();
        m_ovf = 1'b0;
        m_fin = 1'b0;
        m_pop = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        e0.chk = 1'b1;
        e0.val = 8'h00;
        din_q.push_back(e0);
        uart_tx_ready = 1'b1;
        cyc(1'b1, 32'h0003_0000, 8'h7E, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00);
        idle(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
